// File: rtl/npc_pkg.sv
// Shared types and constants for the npc instruction fetch path.
// No logic is held here; the package is pure declarations.
// No flow control; importers decide how these types move.
package npc_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } ifu_state_e;

  // One buffered fetch: the instruction word tagged with its pc.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/npc_sync_fifo.sv
// Generic synchronous FIFO with a synchronous flush and a count output.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the producer must never push when full.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   flush                 empties the FIFO (wins over push and pop)
//   push, push_dat        write one entry
//   pop                   drop the head entry (ignored when empty)
//   head_vld, head_dat    head entry, driven straight from storage flops
//   count                 number of entries held
module npc_sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  assign do_pop   = pop && (cnt != '0);
  assign head_vld = (cnt != '0);
  assign head_dat = mem[rd_ptr];
  assign count    = cnt;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/npc_ifu.sv
// Instruction fetch unit feeding the npc core with {inst, inst_pc}.
// Latency: response in cycle N+k for a request accepted in cycle N appears at inst in N+k+1.
// Backpressure: requests stop once in-flight plus buffered fetches reach DEPTH credits.
//
// Optional build macro IFU_PERF_CNT_EN enables the perf counters; otherwise they read 0.
//
// Ports:
//   clk, rst                                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr                  word fetch request channel
//   imem_rsp_valid/data                        in-order fetch responses, always accepted
//   inst_valid/ready, inst, inst_pc            buffered instruction toward the core
//   redirect_valid, redirect_pc                one-cycle pulse restarting fetch
//   perf_fetch_cnt, perf_stall_cnt             delivered-instruction and empty-buffer counters
module npc_ifu
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e      state;
  logic [XLEN-1:0] fetch_pc;
  // pc of the next response that will be kept; responses return in order and
  // requests are sequential from the last redirect, so a counter suffices.
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop_nxt;
  logic [XLEN-1:0] redirect_tgt;

  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Credits cover both outstanding requests and buffered words, so a response
  // always finds a free FIFO slot.
  assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = (state != IDLE) && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire     = imem_req_valid && imem_req_ready;
  assign pop          = inst_valid && inst_ready;
  assign redirect_tgt = word_align(redirect_pc);

  // A response in the redirect cycle is stale by definition and still retires a credit.
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
  assign rsp_keep     = imem_rsp_valid && !redirect_valid && (drop == '0);

  always_comb begin
    drop_nxt = drop;
    if (imem_rsp_valid && (drop != '0)) begin
      drop_nxt = drop - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        // Every request still outstanding after this edge belongs to the old stream.
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        drop     <= inflight_nxt;
        state    <= (inflight_nxt != '0) ? FLUSH : FETCH;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + PC_STEP;
        end
        drop <= drop_nxt;
        case (state)
          IDLE:    state <= FETCH;
          FETCH:   state <= FETCH;
          FLUSH:   state <= (drop_nxt == '0) ? FETCH : FLUSH;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  npc_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .push_dat (push_entry),
    .pop      (pop),
    .head_vld (inst_valid),
    .head_dat (head_entry),
    .count    (fifo_count)
  );

  assign inst    = head_entry.inst;
  assign inst_pc = head_entry.pc;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((state != IDLE) && !inst_valid) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_ifu.sv
// Testbench for npc_ifu: directed scenarios plus a randomized run against a queue-based model.
// Latency: checks once per cycle on the falling edge; inputs change on the same falling edge.
// Backpressure: memory ready, response timing and core ready are randomized per cycle.
module tb_npc_ifu;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  npc_ifu #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: addresses of outstanding requests (with a stale flag),
  // the buffered {pc, word} stream, and the next expected fetch address.
  logic [31:0] pend_addr[$];
  bit          pend_stale[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_fetch_pc;
  bit          m_idle;
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;
  bit          prev_stuck;
  logic [31:0] prev_addr;

  int n_vec;
  int n_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    check("rst_req_valid",  imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid,     1'b0);
    check("rst_req_addr",   imem_req_addr,  RST_PC);
    check("rst_inst",       inst,           32'h0);
    check("rst_inst_pc",    inst_pc,        32'h0);
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_stall", perf_stall_cnt, 32'h0);
    pend_addr.delete();
    pend_stale.delete();
    q_pc.delete();
    q_inst.delete();
    m_fetch_pc = RST_PC;
    m_idle     = 1'b1;
    m_fcnt     = '0;
    m_scnt     = '0;
    prev_stuck = 1'b0;
    prev_addr  = '0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model across the coming edge.
  task automatic cycle(input int p_ready, input int p_rsp, input int p_iready,
                       input bit redir, input logic [31:0] rpc);
    bit          exp_req;
    bit          exp_iv;
    bit          acc;
    bit          hs;
    bit          rsp_v;
    bit          stale;
    logic [31:0] a;
    @(negedge clk);
    exp_req = !m_idle && ((pend_addr.size() + q_pc.size()) < DEPTH);
    exp_iv  = (q_pc.size() != 0);
    check("req_valid", imem_req_valid, exp_req);
    if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
    if (prev_stuck) check("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, prev_addr});
    check("inst_valid", inst_valid, exp_iv);
    if (exp_iv) begin
      check("inst_pc", inst_pc, q_pc[0]);
      check("inst",    inst,    q_inst[0]);
    end
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, m_fcnt);
    check("perf_stall", perf_stall_cnt, m_scnt);
`else
    check("perf_fetch_off", perf_fetch_cnt, 32'h0);
    check("perf_stall_off", perf_stall_cnt, 32'h0);
`endif

    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    rsp_v          = (pend_addr.size() != 0) && ($urandom_range(0, 99) < p_rsp);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? mem_word(pend_addr[0]) : $urandom;
    inst_ready     = ($urandom_range(0, 99) < p_iready);
    redirect_valid = redir;
    redirect_pc    = rpc;

    acc = exp_req && imem_req_ready;
    hs  = exp_iv && inst_ready;
    if (hs) m_fcnt++;
    if (!m_idle && !exp_iv) m_scnt++;
    if (hs) begin
      void'(q_pc.pop_front());
      void'(q_inst.pop_front());
    end
    if (rsp_v) begin
      a     = pend_addr.pop_front();
      stale = pend_stale.pop_front();
      if (!stale && !redir) begin
        q_pc.push_back(a);
        q_inst.push_back(mem_word(a));
      end
    end
    prev_stuck = exp_req && !imem_req_ready && !redir;
    prev_addr  = m_fetch_pc;
    if (acc) begin
      pend_addr.push_back(m_fetch_pc);
      pend_stale.push_back(redir);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redir) begin
      for (int i = 0; i < pend_stale.size(); i++) pend_stale[i] = 1'b1;
      q_pc.delete();
      q_inst.delete();
      m_fetch_pc = rpc & ~32'h3;
    end
    m_idle = 1'b0;
  endtask

  task automatic run_until_valid(input string tag, input logic [31:0] exp_pc);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 30) begin
      cycle(100, 100, 100, 1'b0, 32'h0);
      n++;
      if (inst_valid === 1'b1) begin
        seen = 1'b1;
        check(tag, inst_pc, exp_pc);
      end
    end
    check({tag, "_seen"}, seen, 1'b1);
  endtask

  initial begin
    logic [31:0] rpc;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;

    // Streaming with an always-ready memory and core.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(100, 100, 100, 1'b0, 32'h0);

    // Core stalled: credits cap requests, buffer holds the first two words.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(100, 100, 0, 1'b0, 32'h0);
    check("stall_head_pc",   inst_pc,        32'h8000_0000);
    check("stall_req_valid", imem_req_valid, 1'b0);
    cycle(100, 100, 100, 1'b0, 32'h0);
    cycle(100, 100, 0,   1'b0, 32'h0);
    check("stall_second_pc", inst_pc,        32'h8000_0004);

    // Memory not ready: request held stable.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(100, 100, 100, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(0,   100, 100, 1'b0, 32'h0);
    check("hold_req_valid", imem_req_valid, 1'b1);
    check("hold_req_addr",  imem_req_addr,  32'h8000_0008);

    // Redirect with two requests outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(100, 0, 100, 1'b0, 32'h0);
    cycle(100, 0, 100, 1'b1, 32'h8000_1003);
    run_until_valid("redir_first_pc", 32'h8000_1000);

    // Redirect coinciding with an accept and a response.
    do_reset();
    cycle(100, 0, 100, 1'b0, 32'h0);
    cycle(100, 0, 100, 1'b0, 32'h0);
    cycle(100, 100, 100, 1'b1, 32'h9000_0000);
    run_until_valid("redir_coinc_pc", 32'h9000_0000);

    // Address wrap past 2^32.
    cycle(100, 100, 100, 1'b1, 32'hFFFF_FFFA);
    run_until_valid("wrap_first_pc", 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) cycle(100, 100, 100, 1'b0, 32'h0);

    // Randomized traffic with occasional redirects and one mid-run reset.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(70, 60, 70, ($urandom_range(0, 99) < 4), rpc);
    end
    cycle(100, 100, 100, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
